// File: rtl/regfile_tagged.sv
// Register file with a per-register rename tag table: issue marks a register busy
// under a producer tag, result broadcasts matching that tag deliver the value.
module regfile_tagged #(
  parameter int WIDTH = 16,
  parameter int NREGS = 8,
  parameter int NWB   = 2,
  parameter int TAGW  = 3,
  localparam int AW   = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   iss_en,
  input  logic [AW-1:0]          iss_dest,
  input  logic [TAGW-1:0]        iss_tag,
  input  logic [NWB-1:0]         wb_valid,
  input  logic [NWB*TAGW-1:0]    wb_tag,
  input  logic [NWB*WIDTH-1:0]   wb_data,
  input  logic                   flush,
  output logic [NREGS*WIDTH-1:0] reg_data,
  output logic [NREGS-1:0]       reg_busy,
  output logic [NREGS*TAGW-1:0]  reg_tag
);

  logic [NREGS-1:0][WIDTH-1:0] data_q, data_d;
  logic [NREGS-1:0]            busy_q, busy_d;
  logic [NREGS-1:0][TAGW-1:0]  tag_q,  tag_d;

  always_comb begin
    data_d = data_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    for (int r = 0; r < NREGS; r++) begin
      // Matching uses only pre-edge tags; ascending scan lets the highest port win.
      if (busy_q[r]) begin
        for (int k = 0; k < NWB; k++) begin
          if (wb_valid[k] && (wb_tag[k*TAGW +: TAGW] == tag_q[r])) begin
            data_d[r] = wb_data[k*WIDTH +: WIDTH];
            busy_d[r] = 1'b0;
          end
        end
      end
      // Status fields: flush clears every rename, otherwise a new issue overrides a wakeup.
      if (flush) begin
        busy_d[r] = 1'b0;
      end else if (iss_en && (iss_dest == AW'(r))) begin
        busy_d[r] = 1'b1;
        tag_d[r]  = iss_tag;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
      busy_q <= '0;
      tag_q  <= '0;
    end else begin
      data_q <= data_d;
      busy_q <= busy_d;
      tag_q  <= tag_d;
    end
  end

  assign reg_data = data_q;
  assign reg_busy = busy_q;
  assign reg_tag  = tag_q;

endmodule

// File: tb/tb_regfile_tagged.sv
// Directed bench for regfile_tagged: each step queues its expected register
// state, the queue is drained and compared after the clock edge.
module tb_regfile_tagged;
  localparam int WIDTH = 16;
  localparam int NREGS = 8;
  localparam int NWB   = 2;
  localparam int TAGW  = 3;
  localparam int AW    = 3;

  logic                   clk = 1'b0;
  logic                   reset;
  logic                   iss_en;
  logic [AW-1:0]          iss_dest;
  logic [TAGW-1:0]        iss_tag;
  logic [NWB-1:0]         wb_valid;
  logic [NWB*TAGW-1:0]    wb_tag;
  logic [NWB*WIDTH-1:0]   wb_data;
  logic                   flush;
  logic [NREGS*WIDTH-1:0] reg_data;
  logic [NREGS-1:0]       reg_busy;
  logic [NREGS*TAGW-1:0]  reg_tag;

  regfile_tagged #(.WIDTH(WIDTH), .NREGS(NREGS), .NWB(NWB), .TAGW(TAGW)) dut (
    .clk(clk), .reset(reset), .iss_en(iss_en), .iss_dest(iss_dest), .iss_tag(iss_tag),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data), .flush(flush),
    .reg_data(reg_data), .reg_busy(reg_busy), .reg_tag(reg_tag)
  );

  always #5 clk = ~clk;

  typedef struct {
    string           name;
    int              r;
    logic [WIDTH-1:0] data;
    logic            busy;
    logic [TAGW-1:0] tag;
    bit              chk_tag;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad   = 0;

  task automatic clr();
    reset = 1'b0; iss_en = 1'b0; iss_dest = '0; iss_tag = '0;
    wb_valid = '0; wb_tag = '0; wb_data = '0; flush = 1'b0;
  endtask

  task automatic issue(input int r, input int t);
    iss_en = 1'b1; iss_dest = AW'(r); iss_tag = TAGW'(t);
  endtask

  task automatic bcast(input int p, input int t, input logic [WIDTH-1:0] d);
    wb_valid[p] = 1'b1;
    wb_tag[p*TAGW +: TAGW]   = TAGW'(t);
    wb_data[p*WIDTH +: WIDTH] = d;
  endtask

  task automatic expect_reg(input string nm, input int r, input logic [WIDTH-1:0] d,
                            input logic b, input int t, input bit ct);
    exp_t e;
    e.name = nm; e.r = r; e.data = d; e.busy = b; e.tag = TAGW'(t); e.chk_tag = ct;
    q.push_back(e);
  endtask

  task automatic tick_and_check();
    exp_t e;
    logic [WIDTH-1:0] od;
    logic [TAGW-1:0]  ot;
    @(posedge clk);
    #1;
    while (q.size() > 0) begin
      e  = q.pop_front();
      od = reg_data[e.r*WIDTH +: WIDTH];
      ot = reg_tag[e.r*TAGW +: TAGW];
      total++;
      assert (od === e.data) else begin
        bad++;
        $error("FAIL %s R%0d data observed=%h expected=%h", e.name, e.r, od, e.data);
      end
      total++;
      assert (reg_busy[e.r] === e.busy) else begin
        bad++;
        $error("FAIL %s R%0d busy observed=%b expected=%b", e.name, e.r, reg_busy[e.r], e.busy);
      end
      if (e.chk_tag) begin
        total++;
        assert (ot === e.tag) else begin
          bad++;
          $error("FAIL %s R%0d tag observed=%0d expected=%0d", e.name, e.r, ot, e.tag);
        end
      end
    end
    clr();
  endtask

  initial begin
    clr();
    #1;
    // Power-on reset: everything zero.
    reset = 1'b1;
    for (int r = 0; r < NREGS; r++) expect_reg("reset", r, 16'h0000, 1'b0, 0, 1'b1);
    tick_and_check();

    // Give R3 a value, rename it, then reset with competing issue/broadcast.
    issue(3, 5);
    expect_reg("r3_issue", 3, 16'h0000, 1'b1, 5, 1'b1);
    tick_and_check();
    bcast(0, 5, 16'h3333);
    expect_reg("r3_wb", 3, 16'h3333, 1'b0, 5, 1'b0);
    tick_and_check();
    issue(3, 5);
    expect_reg("r3_reissue", 3, 16'h3333, 1'b1, 5, 1'b1);
    tick_and_check();
    reset = 1'b1; issue(3, 1); bcast(0, 5, 16'h7777);
    expect_reg("mid_reset", 3, 16'h0000, 1'b0, 0, 1'b1);
    tick_and_check();

    // Basic rename then wakeup; a stale repeat broadcast is ignored.
    issue(2, 4);
    expect_reg("r2_issue", 2, 16'h0000, 1'b1, 4, 1'b1);
    tick_and_check();
    bcast(0, 4, 16'hBEEF);
    expect_reg("r2_wb", 2, 16'hBEEF, 1'b0, 4, 1'b0);
    tick_and_check();
    bcast(0, 4, 16'h1111);
    expect_reg("r2_stale", 2, 16'hBEEF, 1'b0, 4, 1'b0);
    tick_and_check();

    // Two ports waking two registers in one cycle.
    issue(1, 1);
    tick_and_check();
    issue(5, 2);
    tick_and_check();
    bcast(0, 1, 16'h0011); bcast(1, 2, 16'h0022);
    expect_reg("dual_r1", 1, 16'h0011, 1'b0, 1, 1'b0);
    expect_reg("dual_r5", 5, 16'h0022, 1'b0, 2, 1'b0);
    tick_and_check();

    // Same-cycle wakeup and re-rename of R6.
    issue(6, 3);
    tick_and_check();
    bcast(0, 3, 16'h00AA); issue(6, 7);
    expect_reg("r6_wb_iss", 6, 16'h00AA, 1'b1, 7, 1'b1);
    tick_and_check();
    bcast(0, 3, 16'h0BAD);
    expect_reg("r6_oldtag", 6, 16'h00AA, 1'b1, 7, 1'b1);
    tick_and_check();
    bcast(1, 7, 16'h0077);
    expect_reg("r6_newtag", 6, 16'h0077, 1'b0, 7, 1'b0);
    tick_and_check();

    // New rename not cleared by a same-tag broadcast in its issue cycle.
    issue(7, 6); bcast(0, 6, 16'hDEAD);
    expect_reg("r7_iss_wb", 7, 16'h0000, 1'b1, 6, 1'b1);
    tick_and_check();
    issue(4, 6);
    expect_reg("r4_issue", 4, 16'h0000, 1'b1, 6, 1'b1);
    tick_and_check();
    // Both ports match R4 and R7: highest port wins, both registers update.
    bcast(0, 6, 16'h1234); bcast(1, 6, 16'h5678);
    expect_reg("prio_r4", 4, 16'h5678, 1'b0, 6, 1'b0);
    expect_reg("prio_r7", 7, 16'h5678, 1'b0, 6, 1'b0);
    tick_and_check();

    // Flush drops renames and blocks the simultaneous issue.
    issue(0, 1);
    tick_and_check();
    issue(7, 2);
    expect_reg("r0_busy", 0, 16'h0000, 1'b1, 1, 1'b1);
    tick_and_check();
    flush = 1'b1; issue(0, 2);
    expect_reg("flush_r0", 0, 16'h0000, 1'b0, 1, 1'b1);
    expect_reg("flush_r7", 7, 16'h5678, 1'b0, 2, 1'b1);
    for (int r = 1; r < 7; r++) expect_reg("flush_idle", r, (r == 1) ? 16'h0011 :
      (r == 2) ? 16'hBEEF : (r == 4) ? 16'h5678 : (r == 5) ? 16'h0022 :
      (r == 6) ? 16'h0077 : 16'h0000, 1'b0, 0, 1'b0);
    tick_and_check();

    // Flush still lets a matching broadcast deliver data.
    issue(0, 3);
    tick_and_check();
    flush = 1'b1; bcast(1, 3, 16'h0ABC);
    expect_reg("flush_wb", 0, 16'h0ABC, 1'b0, 3, 1'b1);
    tick_and_check();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
